// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer port-A scheduler.
package fb_pkg;

  localparam int FB_W       = 320;
  localparam int FB_H       = 240;
  localparam int FB_ADDR_W  = 17;
  localparam int PAL_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  typedef struct packed {
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] w;
    logic [7:0] h;
    logic [7:0] color;
  } fill_cmd_t;

  // A rectangle is legal when it is non-empty and lies entirely on screen.
  // The sums are one bit wider than the operands so they cannot wrap.
  function automatic logic fill_cmd_ok(input fill_cmd_t c);
    logic [9:0] x_end;
    logic [8:0] y_end;
    x_end = {1'b0, c.x0} + {1'b0, c.w};
    y_end = {1'b0, c.y0} + {1'b0, c.h};
    return (c.w != 9'd0) && (c.h != 8'd0) &&
           (x_end <= 10'(FB_W)) && (y_end <= 9'(FB_H));
  endfunction

endpackage

// File: rtl/fb_fill_engine.sv
// Rectangle fill engine: validates a command, then walks the rectangle in
// raster order, presenting one pixel write per grant.
//
//   state | meaning
//   IDLE  | waiting for fill_start; invalid commands pulse fill_err
//   RUN   | requesting the port; each grant writes one pixel and advances
//   DONE  | one-cycle fill_done pulse, then back to IDLE
module fb_fill_engine
  import fb_pkg::*;
(
  input  logic                 clk_pixel,
  input  logic                 reset_n,
  input  logic                 fill_start,
  input  logic                 fill_abort,
  input  fill_cmd_t            fill_cmd,
  output logic                 fill_req,
  input  logic                 fill_gnt,
  output logic [FB_ADDR_W-1:0] fill_addr,
  output logic [7:0]           fill_data,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic                 fill_err
);

  fill_state_t          state_q, state_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]           cnt_x_q, cnt_x_d, w_q;
  logic [7:0]           cnt_y_q, cnt_y_d, h_q, color_q;
  logic                 err_q, err_d;
  logic                 load;
  logic [FB_ADDR_W-1:0] start_addr;
  logic [9:0]           row_step;
  logic                 last_col, last_row;

  assign start_addr = 17'(fill_cmd.y0) * 17'(FB_W) + 17'(fill_cmd.x0);
  // Jump from the last pixel of a row to the first pixel of the next one.
  assign row_step   = 10'(FB_W) - {1'b0, w_q} + 10'd1;
  assign last_col   = (cnt_x_q == w_q - 9'd1);
  assign last_row   = (cnt_y_q == h_q - 8'd1);

  // State and address-generator registers.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
      err_q   <= err_d;
      if (load) begin
        w_q     <= fill_cmd.w;
        h_q     <= fill_cmd.h;
        color_q <= fill_cmd.color;
      end
    end
  end

  // Next-state logic; a start in IDLE always beats a simultaneous abort.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          if (fill_cmd_ok(fill_cmd)) begin
            load    = 1'b1;
            addr_d  = start_addr;
            cnt_x_d = '0;
            cnt_y_d = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (fill_gnt) begin
          if (last_col) begin
            addr_d  = addr_q + {7'd0, row_step};
            cnt_x_d = '0;
            cnt_y_d = cnt_y_q + 8'd1;
          end else begin
            addr_d  = addr_q + 17'd1;
            cnt_x_d = cnt_x_q + 9'd1;
          end
          if (last_col && last_row) state_d = DONE;
        end
        // The write granted in the abort cycle still goes out.
        if (fill_abort) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fill_req  = (state_q == RUN);
  assign fill_busy = (state_q == RUN);
  assign fill_done = (state_q == DONE);
  assign fill_err  = err_q;
  assign fill_addr = addr_q;
  assign fill_data = color_q;

endmodule

// File: rtl/fb_port_a_sched.sv
// Port-A scheduler: arbitrates one framebuffer/palette access per cycle
// between the host command stream and the rectangle-fill engine.
module fb_port_a_sched
  import fb_pkg::*;
#(
  parameter bit PAL_SYNC_VBLANK    = 1'b1,
  parameter bit FILL_DURING_ACTIVE = 1'b1
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_is_pal,
  input  logic                  host_we,
  input  logic [FB_ADDR_W-1:0]  host_addr,
  input  logic [23:0]           host_wdata,
  output logic [23:0]           host_rdata,
  output logic                  host_rvalid,
  input  logic                  vblank,
  input  logic                  fill_start,
  input  logic                  fill_abort,
  input  logic [8:0]            fill_x0,
  input  logic [7:0]            fill_y0,
  input  logic [8:0]            fill_w,
  input  logic [7:0]            fill_h,
  input  logic [7:0]            fill_color,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fill_err,
  output logic [FB_ADDR_W-1:0]  rgb_addr,
  output logic [7:0]            rgb_in,
  output logic                  wren_rgb,
  input  logic [7:0]            rgb_out,
  output logic [PAL_ADDR_W-1:0] palette_addr,
  output logic [23:0]           palette_in,
  output logic                  wren_palette,
  input  logic [23:0]           palette_out
);

  fill_cmd_t            fill_cmd;
  logic                 fill_req, fill_gnt, fill_elig, fill_first;
  logic [FB_ADDR_W-1:0] fill_addr;
  logic [7:0]           fill_data;
  logic                 host_gnt, pal_hold, read_busy;
  logic                 last_fill_q;
  logic                 rd1_q, rd2_q, rd1_pal_q, rd2_pal_q;

  assign fill_cmd.x0    = fill_x0;
  assign fill_cmd.y0    = fill_y0;
  assign fill_cmd.w     = fill_w;
  assign fill_cmd.h     = fill_h;
  assign fill_cmd.color = fill_color;

  fb_fill_engine u_fill (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .fill_start(fill_start),
    .fill_abort(fill_abort),
    .fill_cmd  (fill_cmd),
    .fill_req  (fill_req),
    .fill_gnt  (fill_gnt),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .fill_err  (fill_err)
  );

  // Host is stalled while a read is in flight, while a palette write waits
  // for vblank, or when the fill engine holds round-robin priority.
  assign read_busy  = rd1_q | rd2_q;
  assign pal_hold   = PAL_SYNC_VBLANK && host_is_pal && host_we && !vblank;
  assign fill_elig  = fill_req && (FILL_DURING_ACTIVE || vblank);
  assign fill_first = fill_elig && !last_fill_q;
  assign host_ready = reset_n && !read_busy && !pal_hold && !fill_first;
  assign host_gnt   = host_valid && host_ready;
  assign fill_gnt   = fill_elig && !host_gnt;

  // Registered port-A drive; write enables fall back to 0 whenever idle.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      rgb_addr     <= '0;
      rgb_in       <= '0;
      wren_rgb     <= 1'b0;
      palette_addr <= '0;
      palette_in   <= '0;
      wren_palette <= 1'b0;
      last_fill_q  <= 1'b1;
    end else begin
      wren_rgb     <= 1'b0;
      wren_palette <= 1'b0;
      if (host_gnt) begin
        last_fill_q <= 1'b0;
        if (host_is_pal) begin
          palette_addr <= host_addr[PAL_ADDR_W-1:0];
          wren_palette <= host_we;
          if (host_we) palette_in <= host_wdata;
        end else begin
          rgb_addr <= host_addr;
          wren_rgb <= host_we;
          if (host_we) rgb_in <= host_wdata[7:0];
        end
      end else if (fill_gnt) begin
        last_fill_q <= 1'b1;
        rgb_addr    <= fill_addr;
        rgb_in      <= fill_data;
        wren_rgb    <= 1'b1;
      end
    end
  end

  // Read return path: address cycle, RAM cycle, then registered response.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      rd1_q       <= 1'b0;
      rd2_q       <= 1'b0;
      rd1_pal_q   <= 1'b0;
      rd2_pal_q   <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      rd1_q       <= host_gnt && !host_we;
      rd1_pal_q   <= host_is_pal;
      rd2_q       <= rd1_q;
      rd2_pal_q   <= rd1_pal_q;
      host_rvalid <= rd2_q;
      if (rd2_q) host_rdata <= rd2_pal_q ? palette_out : {16'd0, rgb_out};
    end
  end

endmodule
